// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue
// and held pending; a countdown models the fixed latency before it commits.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_mul, is_div, is_signed, issue, idle_start;
    logic [63:0] mul_a, mul_b, prod;
    logic        a_neg, b_neg;
    logic [31:0] num, den, den_safe, uq, ur, quo, rem;

    always_comb begin
        idle_start = start && !busy_q;
        is_mul     = (md_op == OP_MULT) || (md_op == OP_MULTU);
        is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
        is_signed  = (md_op == OP_MULT) || (md_op == OP_DIV);
        issue      = idle_start && (is_mul || is_div);
    end

    // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
    always_comb begin
        mul_a = {{32{is_signed & A[31]}}, A};
        mul_b = {{32{is_signed & B[31]}}, B};
        prod  = mul_a * mul_b;
    end

    // Signed divide runs on magnitudes, then restores signs (truncation toward zero).
    always_comb begin
        a_neg    = is_signed && A[31];
        b_neg    = is_signed && B[31];
        num      = a_neg ? (~A + 32'd1) : A;
        den      = b_neg ? (~B + 32'd1) : B;
        den_safe = (den == 32'd0) ? 32'd1 : den;
        uq       = num / den_safe;
        ur       = num % den_safe;
        quo      = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem      = a_neg ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        if (busy_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (issue) begin
            busy_d = 1'b1;
            if (is_mul) begin
                cnt_d     = CNT_W'(MUL_CYCLES);
                pend_hi_d = prod[63:32];
                pend_lo_d = prod[31:0];
                pend_wr_d = 1'b1;
            end else begin
                // Divide by zero still occupies the unit but leaves HI/LO alone.
                cnt_d     = CNT_W'(DIV_CYCLES);
                pend_hi_d = rem;
                pend_lo_d = quo;
                pend_wr_d = (B != 32'd0);
            end
        end else if (idle_start && md_op == OP_MTHI) begin
            hi_d = A;
        end else if (idle_start && md_op == OP_MTLO) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
